// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-to-1 multiplexer feeding a one-entry output register.
//
// Channel choice comes from one of two sources. With MODE 0 it is the
// "select" input. With MODE 1 it is a round-robin search that starts at
// an internal pointer. The chosen word is loaded into m_out one cycle
// after its ready_out bit is high.
//
// Handshake rules (valid/ready):
//   - A channel word moves on a rising edge where valid_in[i] and
//     ready_out[i] are both high. ready_out depends combinationally on
//     valid_in, select, m_ready and the current state.
//   - The output word is consumed on a rising edge where m_valid and
//     m_ready are both high. m_out, m_chan and m_valid stay stable while
//     m_valid is high and m_ready is low.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   data_in      CHANNELS*WIDTH packed words; channel i is [i*WIDTH +: WIDTH]
//   valid_in     per-channel offer
//   ready_out    per-channel take strobe (at most one bit high)
//   select       channel choice in MODE 0; ignored in MODE 1
//   m_out        registered output word
//   m_valid      m_out holds an unconsumed word
//   m_ready      downstream accepts m_out
//   m_chan       channel that produced m_out
//   dbg_state_o  current FSM state (0 = EMPTY, 1 = FULL)
//   dbg_ptr_o    round-robin search start pointer (always 0 in MODE 0)
module mux_nx1_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    output logic [CHANNELS-1:0]       ready_out,
    input  logic [SELW-1:0]           select,
    output logic [WIDTH-1:0]          m_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SELW-1:0]           m_chan,
    output logic                      dbg_state_o,
    output logic [SELW-1:0]           dbg_ptr_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_out_q, m_out_d;
    logic [SELW-1:0]  m_chan_q, m_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;

    // The register can take a new word when empty, or when the word it
    // holds leaves on this same edge.
    assign load_en = (state_q == EMPTY) || m_ready;

    // Grant selection.
    always_comb begin
        int c;
        c         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (MODE == 1) begin
            // Search ptr, ptr+1, ... wrapping; the first requester wins.
            for (int k = 0; k < CHANNELS; k++) begin
                c = int'(ptr_q) + k;
                if (c >= CHANNELS) begin
                    c = c - CHANNELS;
                end
                if (!grant_vld && valid_in[c]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(c);
                end
            end
        end else begin
            // The loop covers only real channels, so an out-of-range select
            // never matches and produces no grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (select == SELW'(i) && valid_in[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    // Take strobe. It is gated by reset so that nothing is taken while
    // the register is held clear.
    always_comb begin
        ready_out = '0;
        if (load_en && grant_vld && !reset) begin
            ready_out[grant_idx] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        m_out_d  = m_out_q;
        m_chan_d = m_chan_q;
        ptr_d    = ptr_q;
        if (load_en) begin
            if (grant_vld) begin
                state_d  = FULL;
                m_out_d  = data_in[int'(grant_idx)*WIDTH +: WIDTH];
                m_chan_d = grant_idx;
                if (MODE == 1) begin
                    ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                // Drain or idle with no new word. The data registers hold.
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            m_out_q  <= '0;
            m_chan_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_out_q  <= m_out_d;
            m_chan_q <= m_chan_d;
            ptr_q    <= ptr_d;
        end
    end

    assign m_out       = m_out_q;
    assign m_chan      = m_chan_q;
    assign m_valid     = (state_q == FULL);
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Testbench for mux_nx1_rr. It drives three instances from one clock and
// one reset:
//   u0: MODE 0, CHANNELS 4
//   u1: MODE 1, CHANNELS 4
//   u2: MODE 0, CHANNELS 3
// A behavioural reference model predicts ready_out before each edge and
// the output register after it. Directed steps cover the listed scenarios,
// and a randomized phase follows.
module tb_mux_nx1_rr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] din [3];
    logic [3:0]  vin [3];
    logic [1:0]  sel [3];
    logic        mrdy [3];

    logic [3:0] ro0, ro1;
    logic [2:0] ro2;
    logic [7:0] mo0, mo1, mo2;
    logic       mv0, mv1, mv2;
    logic [1:0] mc0, mc1, mc2;
    logic       ds0, ds1, ds2;
    logic [1:0] dp0, dp1, dp2;

    mux_nx1_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u0 (
        .clock(clk), .reset(rst), .data_in(din[0]), .valid_in(vin[0]),
        .ready_out(ro0), .select(sel[0]), .m_out(mo0), .m_valid(mv0),
        .m_ready(mrdy[0]), .m_chan(mc0), .dbg_state_o(ds0), .dbg_ptr_o(dp0)
    );

    mux_nx1_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u1 (
        .clock(clk), .reset(rst), .data_in(din[1]), .valid_in(vin[1]),
        .ready_out(ro1), .select(sel[1]), .m_out(mo1), .m_valid(mv1),
        .m_ready(mrdy[1]), .m_chan(mc1), .dbg_state_o(ds1), .dbg_ptr_o(dp1)
    );

    mux_nx1_rr #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u2 (
        .clock(clk), .reset(rst), .data_in(din[2][23:0]), .valid_in(vin[2][2:0]),
        .ready_out(ro2), .select(sel[2]), .m_out(mo2), .m_valid(mv2),
        .m_ready(mrdy[2]), .m_chan(mc2), .dbg_state_o(ds2), .dbg_ptr_o(dp2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per instance.
    int          ch_n   [3] = '{4, 4, 3};
    int          mode_n [3] = '{0, 1, 0};
    bit          m_v [3];
    logic [7:0]  m_o [3];
    int          m_c [3];
    int          m_p [3];
    bit          p_load [3];
    bit          p_found [3];
    int          p_g [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_ro(input int i);
        case (i)
            0:       return {28'd0, ro0};
            1:       return {28'd0, ro1};
            default: return {29'd0, ro2};
        endcase
    endfunction

    function automatic logic [31:0] get_out(input int i, input int which);
        logic [7:0] o;
        logic       v;
        logic [1:0] c;
        logic       s;
        logic [1:0] p;
        case (i)
            0:       begin o = mo0; v = mv0; c = mc0; s = ds0; p = dp0; end
            1:       begin o = mo1; v = mv1; c = mc1; s = ds1; p = dp1; end
            default: begin o = mo2; v = mv2; c = mc2; s = ds2; p = dp2; end
        endcase
        case (which)
            0:       return {24'd0, o};
            1:       return {31'd0, v};
            2:       return {30'd0, c};
            3:       return {31'd0, s};
            default: return {30'd0, p};
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_o[i] = 8'h00;
            m_c[i] = 0;
            m_p[i] = 0;
        end
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_u%0d_m_out", tag, i),   get_out(i, 0), {24'd0, m_o[i]});
            check($sformatf("%s_u%0d_m_valid", tag, i), get_out(i, 1), {31'd0, m_v[i]});
            check($sformatf("%s_u%0d_m_chan", tag, i),  get_out(i, 2), 32'(m_c[i]));
            check($sformatf("%s_u%0d_state", tag, i),   get_out(i, 3), {31'd0, m_v[i]});
            check($sformatf("%s_u%0d_ptr", tag, i),     get_out(i, 4), 32'(m_p[i]));
        end
    endtask

    // One clock cycle. Inputs are already set. The task predicts and
    // checks ready_out, moves across the edge, then updates the model and
    // checks the outputs.
    task automatic step(input string tag);
        logic [31:0] exp_ro;
        #1;
        for (int i = 0; i < 3; i++) begin
            p_found[i] = 1'b0;
            p_g[i]     = 0;
            if (mode_n[i] == 0) begin
                if (int'(sel[i]) < ch_n[i] && vin[i][sel[i]]) begin
                    p_found[i] = 1'b1;
                    p_g[i]     = int'(sel[i]);
                end
            end else begin
                for (int k = 0; k < ch_n[i]; k++) begin
                    if (!p_found[i] && vin[i][(m_p[i] + k) % ch_n[i]]) begin
                        p_found[i] = 1'b1;
                        p_g[i]     = (m_p[i] + k) % ch_n[i];
                    end
                end
            end
            p_load[i] = !m_v[i] || mrdy[i];
            exp_ro = (!rst && p_load[i] && p_found[i]) ? (32'd1 << p_g[i]) : 32'd0;
            check($sformatf("%s_u%0d_ready_out", tag, i), get_ro(i), exp_ro);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (p_load[i]) begin
                    if (p_found[i]) begin
                        m_v[i] = 1'b1;
                        m_o[i] = din[i][p_g[i]*8 +: 8];
                        m_c[i] = p_g[i];
                        if (mode_n[i] == 1) m_p[i] = (p_g[i] + 1) % ch_n[i];
                    end else begin
                        m_v[i] = 1'b0;
                    end
                end
            end
        end
        #1;
        check_outs(tag);
    endtask

    // Asserts reset between edges and checks that the outputs clear at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_clear();
        #1;
        check_outs(tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i]  = 32'h0;
            vin[i]  = 4'h0;
            sel[i]  = 2'd0;
            mrdy[i] = 1'b0;
        end
        model_clear();
        #1;
        do_reset("por");
        @(posedge clk);
        #1;
        // While reset is held, valid requests must be refused.
        for (int i = 0; i < 3; i++) begin
            vin[i]  = 4'hF;
            mrdy[i] = 1'b1;
        end
        step("in_reset");
        rst = 1'b0;

        // Fixed select picks channel 2. Round robin starts at 0.
        // Select 3 is out of range for the 3-channel instance.
        din[0] = 32'h44332211; vin[0] = 4'hF; sel[0] = 2'd2; mrdy[0] = 1'b1;
        din[1] = 32'hD3C2B1A0; vin[1] = 4'hF; sel[1] = 2'd0; mrdy[1] = 1'b1;
        din[2] = 32'h00665544; vin[2] = 4'h7; sel[2] = 2'd3; mrdy[2] = 1'b1;
        #1;
        check("sel2_ready", {28'd0, ro0}, 32'h4);
        check("oor_ready", {29'd0, ro2}, 32'h0);
        step("s1");
        check("sel2_m_out", {24'd0, mo0}, 32'h33);
        check("sel2_m_chan", {30'd0, mc0}, 32'd2);
        check("rr_chan_0", {30'd0, mc1}, 32'd0);
        check("oor_m_valid", {31'd0, mv2}, 32'd0);

        // Back-pressure on u0. u1 keeps rotating.
        mrdy[0] = 1'b0; sel[0] = 2'd1;
        #1;
        check("bp_ready", {28'd0, ro0}, 32'h0);
        for (int n = 1; n <= 3; n++) begin
            step("stall");
            check("bp_hold", {24'd0, mo0}, 32'h33);
            check("rr_chan_seq", {30'd0, mc1}, 32'(n));
            check("rr_valid", {31'd0, mv1}, 32'd1);
        end
        mrdy[0] = 1'b1;
        step("release");
        check("bp_next_out", {24'd0, mo0}, 32'h22);
        check("bp_next_chan", {30'd0, mc0}, 32'd1);
        check("rr_wrap_0", {30'd0, mc1}, 32'd0);

        // Move the pointer to 3. Only channel 1 then requests.
        step("rr_to2");
        step("rr_to3");
        check("rr_ptr3", {30'd0, dp1}, 32'd3);
        vin[1] = 4'b0010;
        #1;
        check("skip_ready", {28'd0, ro1}, 32'h2);
        step("skip");
        check("skip_chan", {30'd0, mc1}, 32'd1);
        check("skip_ptr", {30'd0, dp1}, 32'd2);
        vin[1] = 4'b0000;
        step("drain");
        check("drain_valid", {31'd0, mv1}, 32'd0);
        check("drain_ptr", {30'd0, dp1}, 32'd2);

        // Load AA into u1, then assert reset in the middle of a cycle.
        din[1] = 32'h000000AA; vin[1] = 4'b0001;
        step("load_aa");
        check("aa_out", {24'd0, mo1}, 32'hAA);
        mrdy[1] = 1'b0;
        do_reset("mid_rst");
        check("mid_rst_valid", {31'd0, mv1}, 32'd0);
        check("mid_rst_out", {24'd0, mo1}, 32'h0);
        step("mid_rst_hold");
        rst = 1'b0;
        din[1] = 32'hDDCCBBAA; vin[1] = 4'hF; mrdy[1] = 1'b1;
        step("post_rst");
        check("post_rst_chan", {30'd0, mc1}, 32'd0);
        check("post_rst_out", {24'd0, mo1}, 32'hAA);

        // Randomized traffic against the model, with one reset partway.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                din[i]  = $urandom;
                vin[i]  = 4'($urandom_range(0, 15));
                sel[i]  = 2'($urandom_range(0, 3));
                mrdy[i] = ($urandom_range(0, 3) != 0);
            end
            if (n == 200) begin
                do_reset("rnd_rst");
                step("rnd_in_rst");
                rst = 1'b0;
            end else begin
                step("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each data channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 0; 0 = fixed select, 1 = round-robin arbitration.
REQ-004 Local constant SELW SHALL equal max(1, ceil(log2(CHANNELS))).
REQ-005 clock  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 valid_in  input  CHANNELS  bit i high = channel i offers a word.
REQ-009 ready_out  output  CHANNELS  bit i high = channel i word is taken this edge.
REQ-010 select  input  SELW  channel choice in MODE 0; ignored in MODE 1.
REQ-011 m_out  output  WIDTH  registered output word.
REQ-012 m_valid  output  1  m_out holds an unconsumed word.
REQ-013 m_ready  input  1  downstream accepts m_out when m_valid high.
REQ-014 m_chan  output  SELW  channel index that produced m_out.

Function
REQ-015 Block SHALL be a one-entry output register with states EMPTY (m_valid=0) and FULL (m_valid=1).
REQ-016 load_en SHALL be high when state is EMPTY, or FULL with m_ready=1.
REQ-017 MODE 0: grant SHALL be select when select<CHANNELS and valid_in[select]=1; otherwise no grant.
REQ-018 MODE 1: grant SHALL be first channel with valid_in high, searching ptr, ptr+1, ... wrapping at CHANNELS-1 to 0; none if valid_in=0.
REQ-019 ready_out SHALL be combinational: ready_out[g]=1 only for granted channel g and only when load_en=1; all other bits 0.
REQ-020 At most one ready_out bit SHALL be high in any cycle.
REQ-021 On edge with load_en=1 and grant g: m_out<=data_in[g], m_chan<=g, state->FULL.
REQ-022 On edge with load_en=1 and no grant: state->EMPTY; m_out and m_chan SHALL hold their values.
REQ-023 On edge with FULL and m_ready=0: m_out, m_chan, m_valid SHALL hold (no overwrite, no ready_out).
REQ-024 Latency SHALL be exactly 1 cycle from ready_out[g] high to the word on m_out with m_valid=1.
REQ-025 Simultaneous drain and fill (FULL, m_ready=1, grant present) SHALL load the new word with m_valid staying 1; sustained throughput one word per cycle.
REQ-026 MODE 1: ptr SHALL update to (g+1) mod CHANNELS only on an edge where channel g is accepted; otherwise hold.
REQ-027 MODE 0: ptr SHALL remain 0.
REQ-028 Data on non-granted channels SHALL never reach m_out.
REQ-029 m_ready while EMPTY SHALL have no effect.

Reset
REQ-030 reset high SHALL immediately force m_valid=0, m_out=0, m_chan=0, ptr=0, state EMPTY, independent of clock.
REQ-031 While reset high, ready_out SHALL be all 0 and no word accepted.
REQ-032 Reset asserted mid-operation SHALL discard any held word; first edge after release behaves as from EMPTY.

Verification
REQ-033 MODE 0, WIDTH=8, CHANNELS=4: data_in={8'h44,8'h33,8'h22,8'h11}, valid_in=4'b1111, select=2, m_ready=1 -> ready_out=4'b0100, next cycle m_out=8'h33, m_chan=2, m_valid=1.
REQ-034 MODE 0 backpressure: FULL with m_out=8'h33, m_ready=0, select=1 -> ready_out=0, m_out stays 8'h33 for all stalled cycles; m_ready=1 -> next cycle m_out=8'h22, m_chan=1.
REQ-035 MODE 1 fairness: valid_in=4'b1111, m_ready=1 continuously from reset -> m_chan sequence 0,1,2,3,0 on consecutive cycles, m_valid=1 throughout.
REQ-036 MODE 1 skip and wrap: ptr=3, valid_in=4'b0010 -> grant 1, ready_out=4'b0010, ptr becomes 2; then valid_in=0 -> m_valid drops to 0 after drain, ptr holds 2.
REQ-037 Out-of-range select: CHANNELS=3, select=3, valid_in=3'b111 -> ready_out=0, m_valid stays 0.
REQ-038 Reset mid-stream: FULL with m_out=8'hAA, assert reset between edges -> m_valid=0, m_out=0 immediately; after release first accepted word appears one cycle later, MODE 1 starting from channel 0.
